// File: rtl/div_ctrl_pkg.sv
// Shared state encoding and handshake constants for the radix-2 divider (div_ctrl).
package div_ctrl_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration on the {rem, quot} work register: shift left, trial subtract.
module div_ctrl_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [2*DATA_W:0]  work_in,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  work_out
);

    logic [DATA_W+1:0] rem_shift_s;
    logic [DATA_W+1:0] diff_s;
    logic              ge_s;

    // Shifted remainder taken one bit wider so the trial difference carries its own sign.
    always_comb begin
        rem_shift_s = work_in[2*DATA_W:DATA_W-1];
        diff_s      = rem_shift_s - {2'b00, divisor};
        ge_s        = ~diff_s[DATA_W+1];
        if (ge_s) begin
            work_out = {diff_s[DATA_W:0], work_in[DATA_W-2:0], 1'b1};
        end else begin
            work_out = {rem_shift_s[DATA_W:0], work_in[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 divider with start/ready sequencer; result_o = {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    div_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*DATA_W:0]  work_r;
    logic [2*DATA_W:0]  work_next_s;
    logic [DATA_W-1:0]  divisor_r;
    logic               qneg_r;
    logic               rneg_r;
    logic [DATA_W-1:0]  abs_a_s;
    logic [DATA_W-1:0]  abs_b_s;
    logic [DATA_W-1:0]  rem_raw_s;
    logic [DATA_W-1:0]  quot_fix_s;
    logic [DATA_W-1:0]  rem_fix_s;

    // Operand magnitudes for the signed case; DIVU passes raw values through.
    always_comb begin
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            abs_a_s = negate(opdata1_i);
        end else begin
            abs_a_s = opdata1_i;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            abs_b_s = negate(opdata2_i);
        end else begin
            abs_b_s = opdata2_i;
        end
    end

    // Sign fixup; the work register's top bit is always clear after the last step, a set bit saturates.
    always_comb begin
        rem_raw_s = work_r[2*DATA_W-1:DATA_W] | {DATA_W{work_r[2*DATA_W]}};
        if (qneg_r) begin
            quot_fix_s = negate(work_r[DATA_W-1:0]);
        end else begin
            quot_fix_s = work_r[DATA_W-1:0];
        end
        if (rneg_r) begin
            rem_fix_s = negate(rem_raw_s);
        end else begin
            rem_fix_s = rem_raw_s;
        end
    end

    div_ctrl_step #(.DATA_W(DATA_W)) u_step (
        .work_in  (work_r),
        .divisor  (divisor_r),
        .work_out (work_next_s)
    );

    // Sequencer: operand capture, iteration count, result hand-off and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DIV_FREE;
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {(2*DATA_W+1){1'b0}};
            divisor_r <= {DATA_W{1'b0}};
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            result_o  <= {(2*DATA_W){1'b0}};
            ready_o   <= DIV_RESULT_NOT_READY;
            busy_o    <= 1'b0;
        end else if (annul_i) begin
            state_r  <= DIV_FREE;
            cnt_r    <= {CNT_W{1'b0}};
            result_o <= {(2*DATA_W){1'b0}};
            ready_o  <= DIV_RESULT_NOT_READY;
            busy_o   <= 1'b0;
        end else begin
            case (state_r)
                DIV_FREE: begin
                    result_o <= {(2*DATA_W){1'b0}};
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == {DATA_W{1'b0}}) begin
                            state_r <= DIV_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (abs_a_s < abs_b_s) begin
                            state_r  <= DIV_END;
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_o  <= DIV_RESULT_READY;
`endif
                        end else begin
                            state_r   <= DIV_ON;
                            cnt_r     <= {CNT_W{1'b0}};
                            work_r    <= {{(DATA_W+1){1'b0}}, abs_a_s};
                            divisor_r <= abs_b_s;
                            qneg_r    <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            rneg_r    <= signed_div_i & opdata1_i[DATA_W-1];
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                DIV_BYZERO: begin
                    state_r  <= DIV_END;
                    result_o <= {(2*DATA_W){1'b0}};
                    ready_o  <= DIV_RESULT_READY;
                    busy_o   <= 1'b1;
                end
                DIV_ON: begin
                    busy_o <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        state_r  <= DIV_END;
                        result_o <= {rem_fix_s, quot_fix_s};
                        ready_o  <= DIV_RESULT_READY;
                    end else begin
                        work_r <= work_next_s;
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_r  <= DIV_FREE;
                        result_o <= {(2*DATA_W){1'b0}};
                        ready_o  <= DIV_RESULT_NOT_READY;
                        busy_o   <= 1'b0;
                    end else begin
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= DIV_FREE;
                    result_o <= {(2*DATA_W){1'b0}};
                    ready_o  <= DIV_RESULT_NOT_READY;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed operand vectors, expected {rem, quot} and latency queued at issue.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          e0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic ready_q = 1'b0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_EE = 0;
`else
    localparam int LAT_EE = 33;
`endif

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every rising ready is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (ready && !ready_q) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("latency", 64'(cyc - e.e0), 64'(e.lat));
            end
        end
        ready_q = ready;
    end

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat);
        exp_t e;
        int   busy_cnt;
        logic got;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        e.res = exp_res;
        e.lat = lat;
        e.e0  = cyc + 1;
        q.push_back(e);
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        check("ready_timeout", {63'd0, got}, 64'd1);
        start = 1'b0;
        @(negedge clk);
        check("ready_drop", {63'd0, ready}, 64'd0);
        check("result_clear", result, 64'd0);
        check("busy_drop", {63'd0, busy}, 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(lat + 1));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd0;
        op2        = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, LAT_EE);
        run_op(1'b0, 32'd12345, 32'd0, 64'd0, 1);

        // Abort while ON with cnt=10: annul is sampled at E11.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("annul_busy", {63'd0, busy}, 64'd0);
        check("annul_ready", {63'd0, ready}, 64'd0);
        annul = 1'b0;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        run_op(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, LAT_EE);
        run_op(1'b1, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFD, 32'd0}, LAT_EE);

        // Synchronous reset in the middle of an iteration.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("mid_rst_result", result, 64'd0);
        check("mid_rst_ready", {63'd0, ready}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
